// File: rtl/meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : meter_pkg
//  Description : Shared constants, converter state encoding and helper
//                functions for the parking-meter display stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package meter_pkg;

    // Largest value the 4-digit display can show; the converter input is
    // clamped to this.
    localparam logic [15:0] BCD_MAX = 16'd9999;

    // Active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Sequential binary-to-BCD converter states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Segment pattern for one BCD digit; non-decimal codes light nothing.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift,
    // so that the shift carries correctly into the next decimal digit.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage : meter_pkg
`default_nettype wire

// File: rtl/bin16_to_bcd4.sv
`default_nettype none
// ============================================================================
//  Module      : bin16_to_bcd4
//  Description : Sequential shift-add-3 converter, 16-bit binary (<= 9999)
//                to four BCD digits. A start request is accepted only in
//                IDLE; the result, a done pulse and the converted binary value
//                are all registered on the DONE cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin16_to_bcd4
    import meter_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [15:0] bin_i,
    output logic [15:0] bcd_o,
    output logic        done_o,
    output logic [15:0] last_bin_o
);

    conv_state_t state_q;
    logic [15:0] bin_q;      // binary shift register
    logic [15:0] acc_q;      // BCD accumulator
    logic [4:0]  cnt_q;      // remaining shift iterations
    logic [15:0] val_q;      // value being converted, kept intact
    logic [15:0] bcd_q;
    logic        done_q;
    logic [15:0] last_q;

    logic [15:0] acc_adj_d;

    // Per-nibble correction applied before each shift.
    always_comb begin
        acc_adj_d = bcd_adjust(acc_q);
    end

    // Converter FSM: IDLE waits for a start, SHIFT runs 16 iterations,
    // DONE publishes the result and records which value it belongs to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            bin_q   <= 16'd0;
            acc_q   <= 16'd0;
            cnt_q   <= 5'd0;
            val_q   <= 16'd0;
            bcd_q   <= 16'd0;
            done_q  <= 1'b0;
            last_q  <= 16'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        bin_q   <= bin_i;
                        val_q   <= bin_i;
                        acc_q   <= 16'd0;
                        cnt_q   <= 5'd16;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc_q, bin_q} <= {acc_adj_d, bin_q} << 1;
                    cnt_q          <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= acc_q;
                    done_q  <= 1'b1;
                    last_q  <= val_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bcd_o      = bcd_q;
    assign done_o     = done_q;
    assign last_bin_o = last_q;

endmodule : bin16_to_bcd4
`default_nettype wire

// File: rtl/meter_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : meter_display_ctrl
//  Description : Parking-meter display stage. Clamps the seconds-remaining
//                value to 9999, converts it to BCD, multiplexes a 4-digit
//                common-anode 7-segment display and applies the blink rules
//                (zero: 0.5 s on/off, below BLINK_THRESH: 1 s on/off).
//                Build option LEADING_ZERO_BLANK_EN: when defined, leading
//                zero digits above the ones digit are not lit.
//  Revision    : 1.0 - initial release
// ============================================================================
module meter_display_ctrl
    import meter_pkg::*;
#(
    parameter int CLK_HZ       = 100000000,
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_THRESH = 200
) (
    input  logic        SYS_CLK,
    input  logic        RESET,
    input  logic [15:0] Bin16_In,
    output logic [15:0] BCD_Out,
    output logic        Conv_Done,
    output logic [6:0]  SEG,
    output logic [3:0]  AN,
    output logic        DP
);

    localparam int BLINK_DIV = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
    localparam int SCAN_CNT  = (SCAN_DIV > 0) ? SCAN_DIV : 1;
    localparam int SCAN_W    = $clog2(SCAN_CNT + 1);
    localparam int BLINK_W   = $clog2(BLINK_DIV + 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CNT - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [16:0]        THRESH     = 17'(BLINK_THRESH);

    logic [15:0]        clamp_q;
    logic [15:0]        clamp_d;
    logic [15:0]        disp_bin;
    logic               start_d;

    logic [SCAN_W-1:0]  scan_div_q;
    logic [1:0]         scan_idx_q;
    logic [BLINK_W-1:0] blink_div_q;
    logic [1:0]         phase_q;

    logic               blank_d;
    logic               lz_d;
    logic [3:0]         nib_d;
    logic [6:0]         seg_d;
    logic [3:0]         an_d;
    logic [6:0]         seg_q;
    logic [3:0]         an_q;

    // Clamp to the displayable range.
    always_comb begin
        clamp_d = (Bin16_In > BCD_MAX) ? BCD_MAX : Bin16_In;
    end

    // Register the clamped input; the converter compares against this copy.
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            clamp_q <= 16'd0;
        end else begin
            clamp_q <= clamp_d;
        end
    end

    // Request a conversion whenever the input differs from what is displayed.
    always_comb begin
        start_d = (clamp_q != disp_bin);
    end

    bin16_to_bcd4 u_conv (
        .clk_i      (SYS_CLK),
        .rst_i      (RESET),
        .start_i    (start_d),
        .bin_i      (clamp_q),
        .bcd_o      (BCD_Out),
        .done_o     (Conv_Done),
        .last_bin_o (disp_bin)
    );

    // Digit scan: advance the digit index every SCAN_DIV cycles.
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            scan_div_q <= '0;
            scan_idx_q <= 2'd0;
        end else if (scan_div_q == SCAN_LAST) begin
            scan_div_q <= '0;
            scan_idx_q <= scan_idx_q + 2'd1;
        end else begin
            scan_div_q <= scan_div_q + 1'b1;
        end
    end

    // Blink timebase: step the 2-bit phase every half second.
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            blink_div_q <= '0;
            phase_q     <= 2'd0;
        end else if (blink_div_q == BLINK_LAST) begin
            blink_div_q <= '0;
            phase_q     <= phase_q + 2'd1;
        end else begin
            blink_div_q <= blink_div_q + 1'b1;
        end
    end

    // Blink decision from the displayed value (binary twin of BCD_Out).
    always_comb begin
        blank_d = 1'b0;
        if (disp_bin == 16'd0) begin
            blank_d = phase_q[0];
        end else if ({1'b0, disp_bin} < THRESH) begin
            blank_d = phase_q[1];
        end
    end

    // Leading-zero suppression for the selected digit (ones always shown).
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_d = 1'b0;
        case (scan_idx_q)
            2'd3:    lz_d = (BCD_Out[15:12] == 4'd0);
            2'd2:    lz_d = (BCD_Out[15:8]  == 8'd0);
            2'd1:    lz_d = (BCD_Out[15:4]  == 12'd0);
            default: lz_d = 1'b0;
        endcase
    end
`else
    always_comb begin
        lz_d = 1'b0;
    end
`endif

    // Select and decode the current digit, or blank the whole display.
    always_comb begin
        nib_d = BCD_Out[{scan_idx_q, 2'b00} +: 4];
        if (blank_d || lz_d) begin
            seg_d = SEG_BLANK;
            an_d  = 4'hF;
        end else begin
            seg_d = seg_decode(nib_d);
            an_d  = ~(4'b0001 << scan_idx_q);
        end
    end

    // Registered display drive.
    always_ff @(posedge SYS_CLK) begin
        if (RESET) begin
            seg_q <= SEG_BLANK;
            an_q  <= 4'hF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign SEG = seg_q;
    assign AN  = an_q;
    assign DP  = 1'b1;

endmodule : meter_display_ctrl
`default_nettype wire

// File: tb/tb_meter_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_meter_display_ctrl
//  Description : Self-checking bench for meter_display_ctrl (CLK_HZ=8,
//                SCAN_DIV=1). Honours LEADING_ZERO_BLANK_EN if defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_meter_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bin;
    logic [15:0] bcd;
    logic        done;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;

    int errors = 0;
    int checks = 0;

    logic [6:0] segtab [10];

    typedef struct {
        logic [15:0] bin;
        logic [15:0] exp_bcd;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;

    meter_display_ctrl #(
        .CLK_HZ       (8),
        .SCAN_DIV     (1),
        .BLINK_THRESH (200)
    ) dut (
        .SYS_CLK   (clk),
        .RESET     (rst),
        .Bin16_In  (bin),
        .BCD_Out   (bcd),
        .Conv_Done (done),
        .SEG       (seg),
        .AN        (an),
        .DP        (dp)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int p10(input int j);
        int r;
        r = 1;
        for (int k = 0; k < j; k++) r = r * 10;
        return r;
    endfunction

    function automatic int clampv(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int digit(input int v, input int j);
        return (v / p10(j)) % 10;
    endfunction

    function automatic int bcd_of(input int v);
        return (digit(v, 3) << 12) | (digit(v, 2) << 8) | (digit(v, 1) << 4) | digit(v, 0);
    endfunction

    // True if digit j of value v must stay dark in this build.
    function automatic bit lz_sup(input int j, input int v);
`ifdef LEADING_ZERO_BLANK_EN
        return (j > 0) && (v < p10(j));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int an_pos(input logic [3:0] a);
        int r;
        r = -1;
        for (int j = 0; j < 4; j++) begin
            logic [3:0] oh;
            oh = 4'b0001 << j;
            if (a == ~oh) r = j;
        end
        return r;
    endfunction

    function automatic int content_bad(input int v, input logic [3:0] a, input logic [6:0] s);
        int j;
        if (a == 4'hF) return (s == 7'h7F) ? 0 : 1;
        j = an_pos(a);
        if (j < 0) return 1;
        if (lz_sup(j, v)) return 1;
        if (s != segtab[digit(v, j)]) return 1;
        return 0;
    endfunction

    // Watch n cycles of display for value v. half<0: content only;
    // half==0: never blanked; half>0: square-wave blink of that half-period.
    task automatic observe(input int v, input int n, input int half, input string name);
        logic [3:0] an_log [64];
        bit known [64];
        bit lit [64];
        int bad, first, idx0, j, offs;
        bit fitted, ok;
        logic [3:0] oh;
        bad = 0; first = -1; idx0 = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            an_log[i] = an;
            bad += content_bad(v, an, seg);
            if (first < 0 && an != 4'hF && an_pos(an) >= 0) begin
                first = i;
                idx0  = an_pos(an);
            end
        end
        if (first < 0) begin
            check({name, "_lit"}, 0, 1);
            return;
        end
        for (int i = 0; i < n; i++) begin
            j = (((idx0 + i - first) % 4) + 4) % 4;
            known[i] = !lz_sup(j, v);
            lit[i]   = (an_log[i] != 4'hF);
            oh = 4'b0001 << j;
            if (lit[i] && an_log[i] != ~oh) bad++;
        end
        check({name, "_content"}, bad, 0);
        if (half == 0) begin
            offs = 0;
            for (int i = 0; i < n; i++) if (known[i] && !lit[i]) offs++;
            check({name, "_solid"}, offs, 0);
        end else if (half > 0) begin
            fitted = 1'b0;
            for (int t = 0; t < 2 * half; t++) begin
                ok = 1'b1;
                for (int i = 0; i < n; i++) begin
                    if (known[i] && (lit[i] != ((((i + t) / half) % 2) == 0))) ok = 1'b0;
                end
                if (ok) fitted = 1'b1;
            end
            check({name, "_blink"}, int'(fitted), 1);
        end
    endtask

    // Apply bin value already set; wait bounded for Conv_Done.
    task automatic wait_done(output int lat, output bit seen);
        lat = -1; seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                lat  = i - 1;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic convert(input int v, input string name);
        int lat;
        bit seen;
        bin = 16'(v);
        wait_done(lat, seen);
        check({name, "_latency"}, lat, 18);
        check({name, "_bcd"}, int'(bcd), bcd_of(clampv(v)));
    endtask

    initial begin
        int lat, prev, v, c, np, gap, t1, lit1, lit2, lit3;
        int pb [4];
        bit seen;

        segtab[0] = 7'h40; segtab[1] = 7'h79; segtab[2] = 7'h24; segtab[3] = 7'h30;
        segtab[4] = 7'h19; segtab[5] = 7'h12; segtab[6] = 7'h02; segtab[7] = 7'h78;
        segtab[8] = 7'h00; segtab[9] = 7'h10;

        tbl[0] = '{16'hFFFF, 16'h9999};
        tbl[1] = '{16'd0,    16'h0000};
        tbl[2] = '{16'd10000, 16'h9999};
        tbl[3] = '{16'd42,   16'h0042};
        tbl[4] = '{16'd9999, 16'h9999};
        tbl[5] = '{16'd7305, 16'h7305};
        tbl[6] = '{16'd5,    16'h0005};

        // Reset with a nonzero input pending.
        rst = 1'b1;
        bin = 16'd1234;
        repeat (3) tick();
        check("rst_bcd", int'(bcd), 0);
        check("rst_an", int'(an), 15);
        check("rst_seg", int'(seg), 127);
        check("rst_done", int'(done), 0);
        check("rst_dp", int'(dp), 1);
        rst = 1'b0;
        wait_done(lat, seen);
        check("first_latency", lat, 18);
        check("first_bcd", int'(bcd), 16'h1234);
        tick();
        check("done_pulse_width", int'(done), 0);
        observe(1234, 24, 0, "solid1234");

        // Table vectors: clamp boundaries and ordinary values.
        foreach (tbl[i]) begin
            bin = tbl[i].bin;
            wait_done(lat, seen);
            check($sformatf("tbl%0d_latency", i), lat, 18);
            check($sformatf("tbl%0d_bcd", i), int'(bcd), int'(tbl[i].exp_bcd));
            observe(clampv(int'(tbl[i].bin)), 12, -1, $sformatf("tbl%0d", i));
        end

        // Input change while the converter is busy.
        bin = 16'd550;
        np = 0; t1 = 0; gap = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 7) bin = 16'd560;
            if (done) begin
                if (np < 4) pb[np] = int'(bcd);
                if (np == 0) t1 = i;
                if (np == 1) gap = i - t1;
                np++;
            end
        end
        check("busy_pulses", np, 2);
        check("busy_first", pb[0], 16'h0550);
        check("busy_second", pb[1], 16'h0560);
        check("busy_gap", gap, 18);
        prev = 560;

        // Randomized values against the arithmetic model.
        for (int k = 0; k < 20; k++) begin
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 12000));
            c = clampv(v);
            if (c == prev) begin
                bin = 16'(v);
                np = 0;
                repeat (25) begin tick(); if (done) np++; end
                check("rnd_noconv", np, 0);
                check("rnd_hold_bcd", int'(bcd), bcd_of(c));
            end else begin
                convert(v, $sformatf("rnd%0d", k));
            end
            observe(c, 8, -1, $sformatf("rnd%0d", k));
            prev = c;
        end

        // Blink rules.
        convert(199, "v199");
        observe(199, 48, 8, "v199");
        convert(200, "v200");
        observe(200, 32, 0, "v200");
        convert(0, "v0");
        observe(0, 32, 4, "v0");

        // Reset in the middle of a conversion, input then zero.
        bin = 16'd1234;
        repeat (8) tick();
        rst = 1'b1;
        bin = 16'd0;
        repeat (2) tick();
        check("midrst_bcd", int'(bcd), 0);
        check("midrst_an", int'(an), 15);
        rst = 1'b0;
        np = 0;
        repeat (40) begin tick(); if (done) np++; end
        check("midrst_noconv", np, 0);
        check("midrst_bcd_after", int'(bcd), 0);
        observe(0, 32, 4, "midrst0");

        // Leading-zero handling on value 10.
        convert(10, "v10");
        lit1 = 0; lit2 = 0; lit3 = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (an == 4'b1101) lit1++;
            if (an == 4'b1011) lit2++;
            if (an == 4'b0111) lit3++;
            if (an == 4'b1101) check("v10_seg_tens", int'(seg), 7'h79);
        end
`ifdef LEADING_ZERO_BLANK_EN
        check("v10_an3_dark", lit3, 0);
        check("v10_an2_dark", lit2, 0);
`else
        check("v10_an3_shown", int'(lit3 > 0), 1);
        check("v10_an2_shown", int'(lit2 > 0), 1);
`endif
        check("v10_an1_shown", int'(lit1 > 0), 1);
        observe(10, 32, 8, "v10");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_meter_display_ctrl
`default_nettype wire

// File: doc/meter_display_ctrl.md
Name: meter_display_ctrl

Overview:
- Display stage directly downstream of the parking-meter counter.
- Consumes the counter's 16-bit seconds-remaining value and produces the drive for a 4-digit common-anode 7-segment display.
- Converts the value to BCD with a sequential shift-add-3 converter, clamps it to 9999 and multiplexes the four digits.
- Applies the meter blink rules: value 1..199 blinks with a 2 s period; value 0 blinks with a 1 s period.

Parameters:
- CLK_HZ, 100000000, SYS_CLK frequency; sets the 0.5 s blink tick (CLK_HZ/2 cycles).
- SCAN_DIV, 100000, SYS_CLK cycles per digit-scan step (1 kHz per digit at default).
- BLINK_THRESH, 200, values below this (and nonzero) use the slow blink.

Ports:
- SYS_CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- Bin16_In  in  16  seconds remaining, unsigned, from the counter stage.
- BCD_Out  out  16  registered BCD of the clamped value, {thousands, hundreds, tens, ones}.
- Conv_Done  out  1  one-cycle pulse when BCD_Out updates.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- AN  out  4  anode enables, active-low; AN[0] is the ones digit.
- DP  out  1  decimal point, active-low; held 1 (off).

Behaviour:
- One clock (SYS_CLK); reset is synchronous and active-high (RESET). Every output takes its reset value on the first posedge with RESET=1.
- Reset values: BCD_Out=0, Conv_Done=0, SEG=7'h7F, AN=4'hF, DP=1. Internal state: converter IDLE, scan index 0, blink phase 0, all dividers 0.
- Clamp: the converter input is min(Bin16_In, 9999).
- Converter FSM has three states: IDLE, SHIFT, DONE.
  - IDLE: when the clamped input differs from the last converted value, latch it into a 16-bit shift register, clear the 16-bit BCD accumulator, set the iteration count to 16, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble that is >=5, then shift {BCD, bin} left by 1 and decrement the count. Go to DONE when the count reaches 0.
  - DONE: load BCD_Out, pulse Conv_Done for one cycle, record the converted value, go to IDLE.
- Latency: 18 cycles from a sampled input change to the BCD_Out update.
- Input changes during SHIFT are ignored. They are picked up on the next IDLE cycle; no intermediate value appears on BCD_Out.
- Scan: a divider counts to SCAN_DIV-1 and then advances the 2-bit scan index 0→1→2→3→0, wrapping.
  - AN is one-hot-low on the index; SEG is the registered decode of the selected BCD nibble.
  - Display outputs lag the index by 1 cycle.
- Blink: a divider generates a tick every CLK_HZ/2 cycles and increments a 2-bit phase counter (wraps 3→0).
  - The blank decision uses BCD_Out (the displayed value), not Bin16_In.
  - BCD_Out == 0: blank when phase[0]=1, giving 0.5 s on / 0.5 s off.
  - 0 < value < BLINK_THRESH: blank when phase[1]=1, giving 1 s on / 1 s off.
  - Otherwise: never blank.
  - While blanked, AN=4'hF and SEG=7'h7F.
- Nibble values 10–15 cannot occur; the decoder outputs all segments off for them.
- RESET asserted mid-conversion aborts it. BCD_Out returns to 0 and the display shows 0000 (in its blink phase) once RESET deasserts. The first conversion starts on the next cycle if Bin16_In != 0.

Optional Feature:
- LEADING_ZERO_BLANK_EN
  - Defined: the thousands, hundreds and tens digits have their anode held off while they and all higher digits are 0. The ones digit is always shown, so 42 displays as "  42".
  - Undefined: all four digits are always shown, so 42 displays as "0042".
  - Blink rules apply identically in both builds.

Decomposition:
- Package meter_pkg holds:
  - the SEG_* 7-bit active-low digit constants 0–9 and SEG_BLANK;
  - the converter state enum (IDLE/SHIFT/DONE);
  - BCD_MAX=9999.
- One sub-module, bin16_to_bcd4: the sequential converter FSM with a start/done interface.
- The scan, blink and decode logic stays in the top level.

Test Plan:
- Reset: hold RESET 3 cycles with Bin16_In=1234 → BCD_Out=0, AN=F, SEG=7F during reset. Release → Conv_Done pulses 18 cycles later, BCD_Out=16'h1234, solid display.
- Clamp: Bin16_In=16'hFFFF → BCD_Out=16'h9999; Bin16_In=10000 → 16'h9999; Bin16_In=9999 → 16'h9999.
- Blink, slow and solid (CLK_HZ=8, SCAN_DIV=1): Bin16_In=199 → display on 8 cycles, blanked 8 cycles, repeating; Bin16_In=200 → never blanked.
- Blink, zero (same parameters): Bin16_In=0 → alternating 4 cycles on / 4 cycles off; SEG=SEG_0 on all four anodes during on-phases.
- Change during conversion: Bin16_In 550→560 at cycle 5 of SHIFT → BCD_Out goes to 16'h0550 first, then 16'h0560 18 cycles after the next IDLE; exactly two Conv_Done pulses.
- LEADING_ZERO_BLANK_EN defined, Bin16_In=10 → AN[3] and AN[2] never low; AN[1] shows SEG_1, AN[0] shows SEG_0.
